dac_stream_ctrl: RTL and testbench

DAC_STREAM_CTRL -- requirements
Module: dac_stream_ctrl

---
 rtl/dac_stream_ctrl_if.sv | 31 +++
 rtl/dac_stream_ctrl.sv | 122 ++++++++++++
 tb/tb_dac_stream_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dac_stream_ctrl_if.sv
// Control, source handshake and DAC-side signals of the DAC stream controller.
// The master modport drives the stream sources and control; the slave modport is the controller.
interface dac_stream_ctrl_if;
   logic        enable;
   logic        phy_locked;
   logic        s0_valid;
   logic        s1_valid;
   logic [11:0] s0_data_i;
   logic [11:0] s0_data_q;
   logic [11:0] s1_data_i;
   logic [11:0] s1_data_q;
   logic        s0_ready;
   logic        s1_ready;
   logic [11:0] data_i;
   logic [11:0] data_q;
   logic        sample_tick;
   logic [1:0]  state;
   logic [15:0] underrun_cnt;

   modport master (
      output enable, phy_locked, s0_valid, s1_valid,
             s0_data_i, s0_data_q, s1_data_i, s1_data_q,
      input  s0_ready, s1_ready, data_i, data_q, sample_tick, state, underrun_cnt
   );

   modport slave (
      input  enable, phy_locked, s0_valid, s1_valid,
             s0_data_i, s0_data_q, s1_data_i, s1_data_q,
      output s0_ready, s1_ready, data_i, data_q, sample_tick, state, underrun_cnt
   );
endinterface

// File: rtl/dac_stream_ctrl.sv
// DAC stream controller: waits for PHY lock and a settle period, then feeds the DAC one
// sample every DIV cycles from two round-robin arbitrated sources, muting on underrun.
module dac_stream_ctrl #(
   parameter int unsigned DIV           = 4,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic [11:0] MUTE_VAL      = 12'h800
) (
   input  logic               clk,
   input  logic               reset,
   dac_stream_ctrl_if.slave   bus
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DATA_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_SETTLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_slot;
   logic [CNT_W-1:0]    r_settle;
   logic [CNT_W-1:0]    r_underrun_cnt;
   logic                r_last;
   logic [DATA_W-1:0]   r_data_i;
   logic [DATA_W-1:0]   r_data_q;
   logic                w_tick;
   logic                w_grant0;
   logic                w_grant1;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: disable wins, then lock loss, then normal progression
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:      w_state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (bus.phy_locked) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
               if (!bus.phy_locked)
                  w_state_nxt = ST_WAIT_LOCK;
               else if (r_settle == CNT_W'(SETTLE_CYCLES - 1))
                  w_state_nxt = ST_RUN;
            end
            ST_RUN:       if (!bus.phy_locked) w_state_nxt = ST_WAIT_LOCK;
            default:      w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Slot tick and round-robin grant; r_last=1 means source 1 won last time
   always_comb begin
      w_tick   = 1'b0;
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      w_tick   = (r_state == ST_RUN) && (r_slot == CNT_W'(DIV - 1)) &&
                 bus.enable && bus.phy_locked && !reset;
      w_grant0 = w_tick && bus.s0_valid && (!bus.s1_valid || r_last);
      w_grant1 = w_tick && bus.s1_valid && (!bus.s0_valid || !r_last);
   end

   assign bus.s0_ready     = w_grant0;
   assign bus.s1_ready     = w_grant1;
   assign bus.sample_tick  = w_tick;
   assign bus.state        = r_state;
   assign bus.data_i       = r_data_i;
   assign bus.data_q       = r_data_q;
   assign bus.underrun_cnt = r_underrun_cnt;

   // Counters, output sample register and arbitration history
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot         <= '0;
         r_settle       <= '0;
         r_underrun_cnt <= '0;
         r_last         <= 1'b1;
         r_data_i       <= MUTE_VAL;
         r_data_q       <= MUTE_VAL;
      end else begin
         if (r_state == ST_RUN && w_state_nxt == ST_RUN)
            r_slot <= (r_slot == CNT_W'(DIV - 1)) ? '0 : r_slot + CNT_W'(1);
         else
            r_slot <= '0;

         if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE)
            r_settle <= r_settle + CNT_W'(1);
         else
            r_settle <= '0;

         if (w_state_nxt != ST_RUN) begin
            r_data_i <= MUTE_VAL;
            r_data_q <= MUTE_VAL;
         end else if (w_grant0) begin
            r_data_i <= bus.s0_data_i;
            r_data_q <= bus.s0_data_q;
         end else if (w_grant1) begin
            r_data_i <= bus.s1_data_i;
            r_data_q <= bus.s1_data_q;
         end else if (w_tick) begin
            r_data_i <= MUTE_VAL;
            r_data_q <= MUTE_VAL;
            if (r_underrun_cnt != '1)
               r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
         end

         if (w_grant0)      r_last <= 1'b0;
         else if (w_grant1) r_last <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Bench for dac_stream_ctrl: directed scenarios plus random traffic, every cycle compared
// against a cycle-count based reference model of the controller.
module tb_dac_stream_ctrl;

   localparam int unsigned DIV  = 4;
   localparam int unsigned SC   = 8;
   localparam int          MUTE = 'h800;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dac_stream_ctrl_if bus ();

   dac_stream_ctrl #(.DIV(DIV), .SETTLE_CYCLES(SC), .MUTE_VAL(12'h800)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: state number, completed cycles in RUN / SETTLE, output values
   int m_state, m_run_cyc, m_settle_cyc, m_last, m_di, m_dq, m_und;
   int ticks_seen;
   int grant_log[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_run_cyc = 0; m_settle_cyc = 0; m_last = 1;
      m_di = MUTE; m_dq = MUTE; m_und = 0;
   endtask

   // One clock: check current outputs, advance the model, return at the next negedge
   task automatic step();
      int e_tick, g, nxt;
      #1;
      e_tick = (!reset && bus.enable && bus.phy_locked && m_state == 3 &&
                (m_run_cyc % DIV) == DIV - 1) ? 1 : 0;
      g = -1;
      if (e_tick == 1) begin
         if (bus.s0_valid && bus.s1_valid) g = (m_last == 1) ? 0 : 1;
         else if (bus.s0_valid)            g = 0;
         else if (bus.s1_valid)            g = 1;
      end
      chk("state",    int'(bus.state),        m_state);
      chk("tick",     int'(bus.sample_tick),  e_tick);
      chk("s0_ready", int'(bus.s0_ready),     (g == 0) ? 1 : 0);
      chk("s1_ready", int'(bus.s1_ready),     (g == 1) ? 1 : 0);
      chk("data_i",   int'(bus.data_i),       m_di);
      chk("data_q",   int'(bus.data_q),       m_dq);
      chk("underrun", int'(bus.underrun_cnt), m_und);

      if (reset) begin
         model_reset();
      end else begin
         if (!bus.enable) nxt = 0;
         else case (m_state)
            0:       nxt = 1;
            1:       nxt = bus.phy_locked ? 2 : 1;
            2:       nxt = !bus.phy_locked ? 1 : ((m_settle_cyc + 1 == SC) ? 3 : 2);
            default: nxt = bus.phy_locked ? 3 : 1;
         endcase
         m_settle_cyc = (m_state == 2 && nxt == 2) ? m_settle_cyc + 1 : 0;
         m_run_cyc    = (m_state == 3 && nxt == 3) ? m_run_cyc + 1 : 0;
         if (nxt != 3) begin
            m_di = MUTE; m_dq = MUTE;
         end else if (g == 0) begin
            m_di = int'(bus.s0_data_i); m_dq = int'(bus.s0_data_q);
         end else if (g == 1) begin
            m_di = int'(bus.s1_data_i); m_dq = int'(bus.s1_data_q);
         end else if (e_tick == 1) begin
            m_di = MUTE; m_dq = MUTE;
            m_und = (m_und < 65535) ? m_und + 1 : 65535;
         end
         if (g >= 0) m_last = g;
         m_state = nxt;
      end
      ticks_seen += e_tick;
      if (e_tick == 1) grant_log.push_back(g);
      @(negedge clk);
   endtask

   task automatic set_src(input bit v0, input bit v1);
      bus.s0_valid  = v0;
      bus.s1_valid  = v1;
      bus.s0_data_i = 12'($urandom); bus.s0_data_q = 12'($urandom);
      bus.s1_data_i = 12'($urandom); bus.s1_data_q = 12'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, cnt, g0;
      reset = 1'b1;
      bus.enable = 1'b0; bus.phy_locked = 1'b0;
      set_src(1'b0, 1'b0);
      model_reset();
      ticks_seen = 0;
      @(negedge clk);
      repeat (3) step();

      // Startup: lock arrives one cycle after enable
      reset = 1'b0; bus.enable = 1'b1;
      step();
      bus.phy_locked = 1'b1;
      cnt = 0; t0 = ticks_seen;
      while (ticks_seen == t0 && cnt < 100) begin step(); cnt++; end
      chk("first_tick_latency", cnt, 1 + SC + DIV);
      cnt = 0; t0 = ticks_seen;
      while (ticks_seen == t0 && cnt < 100) begin step(); cnt++; end
      chk("tick_period", cnt, DIV);

      // Round-robin with both sources continuously valid
      bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
      bus.s0_data_i = 12'h111; bus.s0_data_q = 12'h222;
      bus.s1_data_i = 12'h333; bus.s1_data_q = 12'h444;
      grant_log.delete();
      cnt = 0;
      while (grant_log.size() < 4 && cnt < 100) begin step(); cnt++; end
      chk("rr_grants", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         g0 = grant_log[0];
         chk("rr_alt1", grant_log[1], 1 - g0);
         chk("rr_alt2", grant_log[2], g0);
         chk("rr_alt3", grant_log[3], 1 - g0);
      end

      // Underrun: two s1 grants then three empty ticks after a fresh reset
      reset = 1'b1; step();
      reset = 1'b0;
      set_src(1'b0, 1'b1);
      grant_log.delete();
      cnt = 0; t0 = ticks_seen;
      while (ticks_seen < t0 + 2 && cnt < 200) begin step(); cnt++; end
      chk("s1_two_grants", grant_log.size(), 2);
      set_src(1'b0, 1'b0);
      cnt = 0; t0 = ticks_seen;
      while (ticks_seen < t0 + 3 && cnt < 200) begin step(); cnt++; end
      chk("underrun_3", int'(bus.underrun_cnt), 3);
      chk("underrun_mute_i", int'(bus.data_i), 'h800);
      chk("underrun_mute_q", int'(bus.data_q), 'h800);

      // Random traffic with occasional lock loss, disable and reset
      for (int i = 0; i < 600; i++) begin
         reset          = ($urandom_range(0, 199) == 0);
         bus.enable     = ($urandom_range(0, 99) != 0);
         bus.phy_locked = ($urandom_range(0, 39) != 0);
         set_src(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6));
         step();
      end

      // Lock loss coinciding with a tick
      reset = 1'b0; bus.enable = 1'b1; bus.phy_locked = 1'b1;
      set_src(1'b1, 1'b1);
      cnt = 0;
      while (!(m_state == 3 && (m_run_cyc % DIV) == DIV - 1) && cnt < 200) begin
         step(); cnt++;
      end
      bus.phy_locked = 1'b0;
      step();
      bus.phy_locked = 1'b1;
      chk("lockloss_state", int'(bus.state), 1);
      chk("lockloss_mute", int'(bus.data_i), 'h800);
      cnt = 0; t0 = ticks_seen;
      while (ticks_seen == t0 && cnt < 100) begin step(); cnt++; end
      chk("lockloss_resettle", cnt, 1 + SC + DIV);

      // Disable in RUN keeps the underrun count; reset clears it
      set_src(1'b0, 1'b0);
      repeat (3 * DIV) step();
      t0 = m_und;
      bus.enable = 1'b0;
      step();
      chk("disable_state", int'(bus.state), 0);
      chk("disable_mute", int'(bus.data_q), 'h800);
      chk("disable_und_held", int'(bus.underrun_cnt), t0);
      step();
      reset = 1'b1; step();
      reset = 1'b0;
      chk("reset_und_clear", int'(bus.underrun_cnt), 0);

      // Saturation: preload the counter near full scale, then keep underrunning
      force dut.r_underrun_cnt = 16'hFFFD;
      #1 release dut.r_underrun_cnt;
      m_und = 'hFFFD;
      step();
      bus.enable = 1'b1;
      repeat (1 + SC + 6 * DIV) step();
      chk("und_saturated", int'(bus.underrun_cnt), 'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
